// File: rtl/mc_sequencer_pkg.sv
// seq_pkg: shared op encoding and defaults for the mc_sequencer program counter.
package seq_pkg;

    typedef enum logic [2:0] {
        SEQ_INC  = 3'd0,
        SEQ_JMP  = 3'd1,
        SEQ_CALL = 3'd2,
        SEQ_RTN  = 3'd3,
        SEQ_SKIP = 3'd4
    } seq_op_t;

    localparam int SEQ_DEFAULT_ADDR_WIDTH  = 8;
    localparam int SEQ_DEFAULT_STACK_DEPTH = 4;

    // A single-entry stack still needs a one-bit pointer.
    function automatic int seq_ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// mc_sequencer_if: ICU-facing control and status bundle of the sequencer.
interface mc_sequencer_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
);
    import seq_pkg::*;

    logic                             step;
    seq_op_t                          op;
    logic [ADDR_WIDTH-1:0]            target;
    logic                             clear_flags;
    logic [ADDR_WIDTH-1:0]            pc_out;
    logic [$clog2(STACK_DEPTH+1)-1:0] depth;
    logic                             overflow;
    logic                             underflow;
    logic                             halted;

    modport master (
        output step, op, target, clear_flags,
        input  pc_out, depth, overflow, underflow, halted
    );

    modport slave (
        input  step, op, target, clear_flags,
        output pc_out, depth, overflow, underflow, halted
    );

endinterface

// File: rtl/mc_sequencer_return_stack.sv
// return_stack: circular LIFO of return addresses; a push when full overwrites the oldest entry.
module return_stack
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = SEQ_DEFAULT_STACK_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_top,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int PW = seq_ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_top;
    logic [PW-1:0]    w_top_inc;
    logic [PW-1:0]    w_top_dec;
    logic [CW-1:0]    r_count;

    assign w_top_inc = (r_top == PW'(DEPTH - 1)) ? '0 : r_top + 1'b1;
    assign w_top_dec = (r_top == '0) ? PW'(DEPTH - 1) : r_top - 1'b1;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_top     = r_mem[r_top];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_top   <= w_top_inc;
            r_count <= o_full ? r_count : r_count + 1'b1;
        end else if (i_pop) begin
            r_top   <= w_top_dec;
            r_count <= r_count - 1'b1;
        end
    end

    // Contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[w_top_inc] <= i_data;
    end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: program counter with CALL/RTN return stack, SKIP, step enable and sticky stack-error flags.
// Optional MC_SEQ_HALT_ON_SELF_JMP_EN: a self-jump latches halted and freezes the sequencer until reset.
module mc_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = SEQ_DEFAULT_ADDR_WIDTH,
    parameter int STACK_DEPTH = SEQ_DEFAULT_STACK_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    mc_sequencer_if.slave bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [ADDR_WIDTH-1:0] w_top;
    logic [DW-1:0]         w_count;
    logic                  w_adv;
    logic                  w_call;
    logic                  w_rtn;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_halted;
    logic                  r_overflow;
    logic                  r_underflow;

    assign w_adv  = bus.step & ~w_halted;
    assign w_call = w_adv & (bus.op == SEQ_CALL);
    assign w_rtn  = w_adv & (bus.op == SEQ_RTN);
    assign w_pop  = w_rtn & ~w_empty;

    // Undefined encodings and an RTN on an empty stack fall through to pc+1.
    always_comb begin
        w_pc_nxt = (bus.op == SEQ_JMP || bus.op == SEQ_CALL) ? bus.target :
                   w_pop                                     ? w_top :
                   (bus.op == SEQ_SKIP)                      ? r_pc + ADDR_WIDTH'(2) :
                                                               r_pc + 1'b1;
    end

    return_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_call),
        .i_pop   (w_pop),
        .i_data  (r_pc + 1'b1),
        .o_top   (w_top),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pc <= '0;
        else if (w_adv) r_pc <= w_pc_nxt;
    end

    // Flags clear regardless of step; a same-edge set wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (w_call & w_full) | (r_overflow & ~bus.clear_flags);
            r_underflow <= (w_rtn & w_empty) | (r_underflow & ~bus.clear_flags);
        end
    end

`ifdef MC_SEQ_HALT_ON_SELF_JMP_EN
    logic r_halted;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_halted <= 1'b0;
        else r_halted <= r_halted | (w_adv & (bus.op == SEQ_JMP) & (bus.target == r_pc));
    end
    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

    assign bus.pc_out    = r_pc;
    assign bus.depth     = w_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
    assign bus.halted    = w_halted;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed stimulus against a queue-based model, checked every cycle plus literal pins.
module tb_mc_sequencer;
    import seq_pkg::*;

    localparam int AW = 8;
    localparam int SD = 4;
`ifdef MC_SEQ_HALT_ON_SELF_JMP_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_sequencer_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) bus();

    mc_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int m_pc;
    int m_stk[$];
    bit m_ovf, m_unf, m_halt;
    bit run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
        m_halt = 0;
    endtask

    // Drive one cycle, then advance the model by the architectural rules.
    task automatic cyc(input bit st, input seq_op_t op, input int tgt, input bit clr);
        int nxt;
        bit adv;
        bus.step = st;
        bus.op = op;
        bus.target = tgt[AW-1:0];
        bus.clear_flags = clr;
        @(posedge clk);
        if (!reset) begin
            adv = st && !m_halt;
            if (clr) begin
                m_ovf = 0;
                m_unf = 0;
            end
            if (adv) begin
                case (op)
                    SEQ_JMP: begin
                        if (HALT_EN && tgt == m_pc) m_halt = 1;
                        nxt = tgt;
                    end
                    SEQ_CALL: begin
                        if (m_stk.size() == SD) begin
                            void'(m_stk.pop_front());
                            m_ovf = 1;
                        end
                        m_stk.push_back((m_pc + 1) % (1 << AW));
                        nxt = tgt;
                    end
                    SEQ_RTN: begin
                        if (m_stk.size() > 0) nxt = m_stk.pop_back();
                        else begin
                            nxt = m_pc + 1;
                            m_unf = 1;
                        end
                    end
                    SEQ_SKIP: nxt = m_pc + 2;
                    default:  nxt = m_pc + 1;
                endcase
                m_pc = nxt % (1 << AW);
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("pc", bus.pc_out, m_pc);
            chk("depth", bus.depth, m_stk.size());
            chk("overflow", bus.overflow, m_ovf);
            chk("underflow", bus.underflow, m_unf);
            chk("halted", bus.halted, m_halt);
        end
    end

    initial begin
        int rets [4] = '{41, 31, 21, 11};
        bus.step = 0;
        bus.op = SEQ_INC;
        bus.target = '0;
        bus.clear_flags = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        run = 1;
        chk("reset_pc", bus.pc_out, 0);
        chk("reset_depth", bus.depth, 0);

        repeat (3) cyc(1, SEQ_INC, 0, 0);
        chk("inc3_pc", bus.pc_out, 3);
        cyc(1, SEQ_RTN, 0, 0);
        chk("early_unf", bus.underflow, 1);
        cyc(1, SEQ_CALL, 20, 0);
        chk("early_depth", bus.depth, 1);
        #2;
        reset = 1;
        model_reset();
        #1;
        chk("async_pc", bus.pc_out, 0);
        chk("async_depth", bus.depth, 0);
        chk("async_unf", bus.underflow, 0);
        cyc(1, SEQ_CALL, 33, 0);
        chk("reset_abort_pc", bus.pc_out, 0);
        reset = 0;

        cyc(1, SEQ_JMP, 254, 0);
        cyc(1, SEQ_INC, 0, 0);
        chk("wrap_255", bus.pc_out, 255);
        cyc(1, SEQ_SKIP, 0, 0);
        chk("skip_wrap", bus.pc_out, 1);
        repeat (2) cyc(0, SEQ_JMP, 99, 0);
        chk("step_hold", bus.pc_out, 1);
        cyc(1, seq_op_t'(3'd6), 77, 0);
        chk("undef_op", bus.pc_out, 2);

        cyc(1, SEQ_JMP, 10, 0);
        cyc(1, SEQ_CALL, 40, 0);
        chk("call1_pc", bus.pc_out, 40);
        chk("call1_depth", bus.depth, 1);
        cyc(1, SEQ_CALL, 80, 0);
        chk("call2_depth", bus.depth, 2);
        cyc(1, SEQ_RTN, 0, 0);
        chk("rtn1_pc", bus.pc_out, 41);
        chk("rtn1_depth", bus.depth, 1);
        cyc(1, SEQ_RTN, 0, 0);
        chk("rtn2_pc", bus.pc_out, 11);
        chk("rtn2_depth", bus.depth, 0);

        cyc(1, SEQ_JMP, 0, 0);
        for (int t = 10; t <= 50; t += 10) cyc(1, SEQ_CALL, t, 0);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_depth", bus.depth, SD);
        for (int i = 0; i < 4; i++) begin
            cyc(1, SEQ_RTN, 0, 0);
            chk("ovf_unwind", bus.pc_out, rets[i]);
        end
        chk("pre_unf", bus.underflow, 0);
        cyc(1, SEQ_RTN, 0, 0);
        chk("lost_entry_pc", bus.pc_out, 12);
        chk("lost_entry_unf", bus.underflow, 1);

        cyc(1, SEQ_RTN, 0, 1);
        chk("set_wins_unf", bus.underflow, 1);
        chk("clr_ovf", bus.overflow, 0);
        cyc(0, SEQ_INC, 0, 1);
        chk("clr_nostep_unf", bus.underflow, 0);
        chk("clr_nostep_pc", bus.pc_out, 13);

        cyc(1, SEQ_JMP, 7, 0);
        cyc(1, SEQ_JMP, 7, 0);
`ifdef MC_SEQ_HALT_ON_SELF_JMP_EN
        chk("halt_set", bus.halted, 1);
        repeat (5) cyc(1, SEQ_INC, 0, 0);
        cyc(1, SEQ_CALL, 90, 1);
        chk("halt_freeze_pc", bus.pc_out, 7);
        chk("halt_sticky", bus.halted, 1);
        reset = 1;
        model_reset();
        #1;
        chk("halt_reset", bus.halted, 0);
        cyc(1, SEQ_INC, 0, 0);
        reset = 0;
`else
        chk("no_halt", bus.halted, 0);
        cyc(1, SEQ_INC, 0, 0);
        chk("self_jmp_inc", bus.pc_out, 8);
`endif
        cyc(1, SEQ_INC, 0, 0);
        run = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Parametrised successor to the plain program counter in the MC14500B-style 1-bit controller.
- Adds CALL/RTN with a hardware return stack of configurable depth, SKIP (conditional skip of the next instruction), a step-enable, and sticky stack-error flags.
- Sits between the ICU (operation source) and the program text RAM, whose read address is pc_out.

Parameters:
- ADDR_WIDTH, 8, width of program address and pc_out.
- STACK_DEPTH, 4, number of return-stack entries; must be >= 1. Need not be a power of two.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- step  input  1  advance enable; when low, all state holds.
- op  input  3  seq_op_t from seq_pkg: SEQ_INC, SEQ_JMP, SEQ_CALL, SEQ_RTN, SEQ_SKIP.
- target  input  ADDR_WIDTH  jump/call destination.
- clear_flags  input  1  clears the sticky error flags.
- pc_out  output  ADDR_WIDTH  current program address.
- depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- overflow  output  1  sticky; a CALL was made while the stack was full.
- underflow  output  1  sticky; an RTN was made while the stack was empty.
- halted  output  1  see Optional Feature; tied 0 when the feature is out.

Behaviour:
- Reset, asynchronous:
  - pc_out=0, depth=0, overflow=0, underflow=0, halted=0.
  - Stack contents are don't-care after reset.
  - Reset asserted mid-operation aborts any update on that edge.
- All updates happen on a rising clk edge with step=1. With step=0, nothing changes except the flag clear described below.
- Arithmetic is modulo 2^ADDR_WIDTH: pc 2^ADDR_WIDTH-1 plus 1 wraps to 0.
- SEQ_INC: pc <= pc+1.
- SEQ_JMP: pc <= target. Stack untouched.
- SEQ_CALL: push pc+1, then pc <= target.
  - When not full: depth <= depth+1.
  - When full (depth==STACK_DEPTH): the oldest entry is discarded (circular overwrite), the new entry becomes the top, depth stays at STACK_DEPTH, and overflow <= 1.
- SEQ_RTN:
  - When not empty: pc <= top entry, depth <= depth-1.
  - When empty: pc <= pc+1, underflow <= 1, depth stays 0.
- SEQ_SKIP: pc <= pc+2.
- Undefined op encodings behave as SEQ_INC.
- Latency: pc_out reflects the operation one cycle after the edge that samples it. The text RAM read is combinational on pc_out.
- Flag clear:
  - clear_flags=1 clears both flags on the rising edge regardless of step.
  - If a flag-setting event occurs on the same edge, the set wins.
- CALL followed immediately by RTN returns to call_address+1, with no bubble cycle.
- A push wrapped by overflow, then fully unwound: the first STACK_DEPTH RTNs return the newest addresses. The next RTN is an underflow; the lost entry is not recovered.

Optional Feature:
- Macro: MC_SEQ_HALT_ON_SELF_JMP_EN.
- Defined:
  - A SEQ_JMP with target==pc_out, sampled with step=1, sets halted<=1. The pc is updated to target as normal, which is the same value.
  - While halted=1, step is ignored and the pc and stack freeze.
  - clear_flags does not clear halted. Only reset clears it.
- Undefined: halted is constant 0, and a self-jump is an ordinary JMP.

Decomposition:
- seq_pkg holds:
  - typedef enum logic [2:0] seq_op_t, with SEQ_INC=0, SEQ_JMP=1, SEQ_CALL=2, SEQ_RTN=3, SEQ_SKIP=4.
  - A localparam for the default stack depth.
- One sub-module, return_stack, parametrised on WIDTH and DEPTH. It contains:
  - the circular LIFO storage;
  - the top pointer and the valid count;
  - push, pop, full and empty signals.
- mc_sequencer owns the pc register, op decode, flags and halt logic.

Test Plan:
- Reset mid-run: after 3 INC (pc=3), assert reset asynchronously between edges -> pc_out=0, depth=0 and flags=0 immediately, without waiting for a clock.
- Wrap and skip: pc=254, INC -> 255, SKIP -> 1. step=0 for 2 edges with op=SEQ_JMP -> pc stays 1.
- Nested call and return: at pc=10, CALL 40. At 40, CALL 80. Then RTN -> 41, RTN -> 11, with depth 1,2,1,0 along the way.
- Overflow, STACK_DEPTH=4: 5 CALLs from pcs 0,10,20,30,40 -> overflow=1, depth=4. Four RTNs return 41,31,21,11. A fifth RTN -> pc+1 and underflow=1.
- Flag priority: clear_flags=1 on the same edge as an RTN on an empty stack -> underflow=1. clear_flags=1 alone on the next edge with step=0 -> underflow=0.
- Halt feature, macro defined: at pc=7, JMP 7 -> halted=1, and pc stays 7 through 5 INC steps. Reset -> halted=0. With the macro undefined: halted=0 and the following INC gives pc=8.
